// File: rtl/ipv4_rx_pkg.sv
// Shared types and constants for the IPv4 receive header parser.
package ipv4_rx_pkg;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [3:0]  IPV4_IHL_MIN = 4'd5;
  localparam logic [7:0]  IP_PROTO_TCP = 8'd6;
  localparam logic [2:0]  HDR_BEATS    = 3'd5;
  localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] total_len;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [7:0]  flags;
    logic        is_tcp;
    logic        csum_ok;
    logic        err_short;
    logic        err_ver;
    logic        err_ihl;
  } ipv4_result_t;

  // One's-complement add with end-around carry; the refolded sum cannot carry again.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[15:0] + {15'd0, t[16]};
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// Header checksum accumulator: folds up to four 16-bit words per beat into a running sum.
module ipv4_csum_acc
  import ipv4_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  word_en,
  input  logic [63:0] data,
  output logic [15:0] sum
);

  logic [15:0] acc;

  // sum already includes the current beat so the parser can decide on the tlast beat.
  always_comb begin
    sum = acc;
    for (int i = 0; i < 4; i++) begin
      if (en && word_en[3-i]) sum = ones_add(sum, data[63-16*i -: 16]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= sum;
  end

endmodule

// File: rtl/ipv4_rx_parser.sv
// IPv4/TCP header parser for a 64-bit AXI-Stream; emits one result record per frame.
//   state     | meaning
//   ST_HDR    | accepting header beats 0..4
//   ST_DRAIN  | header done, discarding payload until tlast
//   ST_RESULT | record valid, input stalled until out_ready
module ipv4_rx_parser
  import ipv4_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ip_ver,
  output logic [3:0]  ip_ihl,
  output logic [15:0] ip_total_len,
  output logic [7:0]  ip_ttl,
  output logic [7:0]  ip_proto,
  output logic [31:0] ip_src,
  output logic [31:0] ip_dst,
  output logic [15:0] tcp_src_port,
  output logic [15:0] tcp_dst_port,
  output logic [31:0] tcp_seq,
  output logic [7:0]  tcp_flags,
  output logic        is_tcp,
  output logic        csum_ok,
  output logic        err_short,
  output logic        err_ver,
  output logic        err_ihl
);

  state_t       state;
  logic [2:0]   beat_cnt;
  ipv4_result_t cap, cap_nxt, fin, res;
  logic         tready_r, out_valid_r;
  logic         accept, last_hs, out_hs;
  logic [3:0]   word_en;
  logic [15:0]  csum_sum;
  logic         short_nxt, got_b2;
  logic         unused_tkeep;

  assign accept  = s_axis_tvalid & tready_r;
  assign last_hs = accept & s_axis_tlast;
  assign out_hs  = out_valid_r & out_ready;

  // Only the last beat's byte enables matter, and only the two flag-carrying bytes.
  assign unused_tkeep = ^s_axis_tkeep[5:0];

  always_comb begin
    word_en = 4'b0000;
    case (beat_cnt)
      3'd0, 3'd1: word_en = 4'b1111;
      3'd2:       word_en = 4'b1100;
      default:    word_en = 4'b0000;
    endcase
  end

  ipv4_csum_acc u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr     (last_hs),
    .en      (accept),
    .word_en (word_en),
    .data    (s_axis_tdata),
    .sum     (csum_sum)
  );

  always_comb begin
    cap_nxt = cap;
    if (accept) begin
      case (beat_cnt)
        3'd0: begin
          cap_nxt.ver       = s_axis_tdata[63:60];
          cap_nxt.ihl       = s_axis_tdata[59:56];
          cap_nxt.total_len = s_axis_tdata[47:32];
        end
        3'd1: begin
          cap_nxt.ttl   = s_axis_tdata[63:56];
          cap_nxt.proto = s_axis_tdata[55:48];
          cap_nxt.src   = s_axis_tdata[31:0];
        end
        3'd2: begin
          cap_nxt.dst      = s_axis_tdata[63:32];
          cap_nxt.src_port = s_axis_tdata[31:16];
          cap_nxt.dst_port = s_axis_tdata[15:0];
        end
        3'd3: cap_nxt.seq   = s_axis_tdata[63:32];
        3'd4: cap_nxt.flags = s_axis_tdata[55:48];
        default: ;
      endcase
    end

    short_nxt = (beat_cnt < HDR_BEATS - 3'd1) ||
                ((beat_cnt == HDR_BEATS - 3'd1) && (s_axis_tkeep[7:6] != 2'b11));
    got_b2    = (beat_cnt >= 3'd2);

    fin           = cap_nxt;
    fin.err_short = short_nxt;
    fin.err_ver   = (cap_nxt.ver != IPV4_VERSION);
    fin.err_ihl   = (cap_nxt.ihl != IPV4_IHL_MIN);
    fin.is_tcp    = (cap_nxt.proto == IP_PROTO_TCP) && (cap_nxt.ihl == IPV4_IHL_MIN) && !short_nxt;
    fin.csum_ok   = got_b2 && (csum_sum == CSUM_GOOD);
    if (!fin.is_tcp) begin
      fin.src_port = '0;
      fin.dst_port = '0;
      fin.seq      = '0;
      fin.flags    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HDR;
      beat_cnt    <= '0;
      cap         <= '0;
      res         <= '0;
      out_valid_r <= 1'b0;
      tready_r    <= 1'b0;
    end else begin
      if (accept) begin
        if (s_axis_tlast) begin
          beat_cnt <= '0;
          cap      <= '0;
        end else begin
          if (beat_cnt != HDR_BEATS) beat_cnt <= beat_cnt + 3'd1;
          cap <= cap_nxt;
        end
      end

      case (state)
        ST_HDR, ST_DRAIN: begin
          tready_r <= 1'b1;
          if (last_hs) begin
            state       <= ST_RESULT;
            tready_r    <= 1'b0;
            res         <= fin;
            out_valid_r <= 1'b1;
          end else if (state == ST_HDR && accept && beat_cnt == HDR_BEATS - 3'd1) begin
            state <= ST_DRAIN;
          end
        end
        ST_RESULT: begin
          tready_r <= 1'b0;
          if (out_hs) begin
            state       <= ST_HDR;
            out_valid_r <= 1'b0;
            tready_r    <= 1'b1;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  assign s_axis_tready = tready_r;
  assign out_valid     = out_valid_r;
  assign ip_ver        = res.ver;
  assign ip_ihl        = res.ihl;
  assign ip_total_len  = res.total_len;
  assign ip_ttl        = res.ttl;
  assign ip_proto      = res.proto;
  assign ip_src        = res.src;
  assign ip_dst        = res.dst;
  assign tcp_src_port  = res.src_port;
  assign tcp_dst_port  = res.dst_port;
  assign tcp_seq       = res.seq;
  assign tcp_flags     = res.flags;
  assign is_tcp        = res.is_tcp;
  assign csum_ok       = res.csum_ok;
  assign err_short     = res.err_short;
  assign err_ver       = res.err_ver;
  assign err_ihl       = res.err_ihl;

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Directed bench for ipv4_rx_parser: hand-computed header records for a set of frame shapes.
module tb_ipv4_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ip_ver, ip_ihl;
  logic [15:0] ip_total_len;
  logic [7:0]  ip_ttl, ip_proto;
  logic [31:0] ip_src, ip_dst;
  logic [15:0] tcp_src_port, tcp_dst_port;
  logic [31:0] tcp_seq;
  logic [7:0]  tcp_flags;
  logic        is_tcp, csum_ok, err_short, err_ver, err_ihl;

  int checks = 0;
  int errors = 0;

  // hdr = {ver, ihl, total_len, ttl, proto, src, dst}
  // tail = {src_port, dst_port, seq, flags, is_tcp, csum_ok, err_short, err_ver, err_ihl}
  localparam logic [103:0] SYN_HDR  = {4'h4, 4'h5, 16'h0028, 8'h40, 8'h06, 32'hC0A80101, 32'hC0A80102};
  localparam logic [76:0]  SYN_TAIL = {16'h04D2, 16'h0050, 32'h00000001, 8'h02, 5'b11000};
  localparam logic [76:0]  BAD_TAIL = {16'h04D2, 16'h0050, 32'h00000001, 8'h02, 5'b10000};
  localparam logic [76:0]  SHORT_TAIL = {16'h0, 16'h0, 32'h0, 8'h0, 5'b01100};
  localparam logic [103:0] OPT_HDR  = {4'h4, 4'h6, 16'h0030, 8'h40, 8'h11, 32'hC0A80101, 32'hC0A80102};
  localparam logic [76:0]  OPT_TAIL = {16'h0, 16'h0, 32'h0, 8'h0, 5'b00001};
  localparam logic [103:0] ONE_HDR  = {4'h6, 4'h5, 16'h0028, 8'h0, 8'h0, 32'h0, 32'h0};
  localparam logic [76:0]  ONE_TAIL = {16'h0, 16'h0, 32'h0, 8'h0, 5'b00110};

  ipv4_rx_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ip_ver(ip_ver), .ip_ihl(ip_ihl), .ip_total_len(ip_total_len), .ip_ttl(ip_ttl),
    .ip_proto(ip_proto), .ip_src(ip_src), .ip_dst(ip_dst),
    .tcp_src_port(tcp_src_port), .tcp_dst_port(tcp_dst_port), .tcp_seq(tcp_seq),
    .tcp_flags(tcp_flags), .is_tcp(is_tcp), .csum_ok(csum_ok), .err_short(err_short),
    .err_ver(err_ver), .err_ihl(err_ihl)
  );

  always #5 clk = ~clk;

  function automatic logic [103:0] cur_hdr();
    return {ip_ver, ip_ihl, ip_total_len, ip_ttl, ip_proto, ip_src, ip_dst};
  endfunction

  function automatic logic [76:0] cur_tail();
    return {tcp_src_port, tcp_dst_port, tcp_seq, tcp_flags, is_tcp, csum_ok, err_short, err_ver, err_ihl};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("tready_timeout", s_axis_tready, 1);
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_syn(input logic [15:0] csum, input logic [7:0] last_keep);
    send_beat(64'h4500002812344000, 8'hFF, 1'b0);
    send_beat({16'h4006, csum, 32'hC0A80101}, 8'hFF, 1'b0);
    send_beat(64'hC0A8010204D20050, 8'hFF, 1'b0);
    send_beat(64'h0000000100000000, 8'hFF, 1'b0);
    send_beat(64'h5002721000000000, last_keep, 1'b1);
  endtask

  task automatic get_rec(input string t, input logic [103:0] hdr, input logic [76:0] tail);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk({t, ".valid"}, out_valid, 1);
    chk({t, ".hdr"}, cur_hdr(), hdr);
    chk({t, ".tail"}, cur_tail(), tail);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({t, ".released"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst.tready", s_axis_tready, 0);
    chk("rst.valid", out_valid, 0);
    chk("rst.hdr", cur_hdr(), 0);
    chk("rst.tail", cur_tail(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.tready_after", s_axis_tready, 1);

    // SYN frame, record must appear the cycle after tlast
    send_syn(16'hA548, 8'hFC);
    chk("syn.valid_next", out_valid, 1);
    chk("syn.tready_low", s_axis_tready, 0);
    get_rec("syn", SYN_HDR, SYN_TAIL);
    chk("syn.tready_back", s_axis_tready, 1);

    // Zeroed checksum field
    send_syn(16'h0000, 8'hFC);
    get_rec("badcsum", SYN_HDR, BAD_TAIL);

    // Short frame ending on beat2
    send_beat(64'h4500002812344000, 8'hFF, 1'b0);
    send_beat(64'h4006A548C0A80101, 8'hFF, 1'b0);
    send_beat(64'hC0A8010204D20050, 8'hFF, 1'b1);
    get_rec("short3", SYN_HDR, SHORT_TAIL);

    // Beat4 tlast with flag bytes not both enabled
    send_syn(16'hA548, 8'h80);
    get_rec("keep80", SYN_HDR, SHORT_TAIL);

    // Single-beat frame with version 6
    send_beat(64'h6500002812344000, 8'hFF, 1'b1);
    get_rec("onebeat", ONE_HDR, ONE_TAIL);

    // Backpressure: record held for 10 cycles, input stalled
    send_syn(16'hA548, 8'hFC);
    for (int i = 0; i < 10; i++) begin
      chk("bp.tready", s_axis_tready, 0);
      chk("bp.valid", out_valid, 1);
      chk("bp.hdr", cur_hdr(), SYN_HDR);
      chk("bp.tail", cur_tail(), SYN_TAIL);
      @(negedge clk);
    end
    get_rec("bp", SYN_HDR, SYN_TAIL);
    send_syn(16'h0000, 8'hFC);
    get_rec("bp_next", SYN_HDR, BAD_TAIL);

    // 9-beat options frame, non-last tkeep values are irrelevant
    send_beat(64'h4600003012344000, 8'hFF, 1'b0);
    send_beat(64'h40110000C0A80101, 8'hFF, 1'b0);
    send_beat(64'hC0A8010211111111, 8'hFF, 1'b0);
    send_beat(64'h0000000100000000, 8'h00, 1'b0);
    send_beat(64'h5002721000000000, 8'h0F, 1'b0);
    send_beat(64'hDEADBEEF01234567, 8'hFF, 1'b0);
    send_beat(64'h89ABCDEF76543210, 8'h01, 1'b0);
    send_beat(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    chk("opt.no_early", out_valid, 0);
    send_beat(64'h0102030405060708, 8'hF0, 1'b1);
    get_rec("opt", OPT_HDR, OPT_TAIL);
    repeat (4) @(negedge clk);
    chk("opt.single", out_valid, 0);

    // Reset in the middle of a frame
    send_beat(64'h4500002812344000, 8'hFF, 1'b0);
    send_beat(64'h4006A548C0A80101, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.tready", s_axis_tready, 0);
    send_syn(16'hA548, 8'hFC);
    get_rec("midrst", SYN_HDR, SYN_TAIL);
    repeat (4) @(negedge clk);
    chk("midrst.single", out_valid, 0);

    // Reset while a record is pending drops it
    send_beat(64'h6500002812344000, 8'hFF, 1'b1);
    chk("rstres.pending", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstres.dropped", out_valid, 0);
    chk("rstres.hdr", cur_hdr(), 0);
    repeat (3) @(negedge clk);
    chk("rstres.still_none", out_valid, 0);
    send_syn(16'hA548, 8'hFC);
    get_rec("recover", SYN_HDR, SYN_TAIL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv4_rx_parser.md
IPV4_RX_PARSER -- requirements
Module: ipv4_rx_parser

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all logic is on its rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have s_axis_tdata, input, 64, Ethernet payload stream; byte 0 is in bits 63:56, and the IPv4 header starts at byte 0 of the first beat.
REQ-004 SHALL have s_axis_tkeep, input, 8, byte enables; tkeep[7] qualifies byte 0.
REQ-005 SHALL have s_axis_tvalid, s_axis_tlast (inputs, 1 each) and s_axis_tready (output, 1): the AXI-Stream slave handshake.
REQ-006 SHALL have out_valid (output, 1) and out_ready (input, 1): the result record handshake.
REQ-007 SHALL have ip_ver (4), ip_ihl (4), ip_total_len (16), ip_ttl (8), ip_proto (8), ip_src (32), ip_dst (32) as result outputs.
REQ-008 SHALL have tcp_src_port (16), tcp_dst_port (16), tcp_seq (32), tcp_flags (8) as result outputs; these are zero unless is_tcp=1.
REQ-009 SHALL have status outputs: is_tcp, csum_ok, err_short, err_ver, err_ihl (1 bit each).

Function
REQ-010 Beat counter beat_cnt (3 bit) SHALL count accepted beats of a frame, saturate at 5, and clear on the tlast handshake.
REQ-011 SHALL capture header fields from these beats:
- beat0: ver/ihl in byte 0, total_len in bytes 2-3.
- beat1: ttl in byte 8, proto in byte 9, src in bytes 12-15.
- beat2: dst in bytes 16-19, src_port in bytes 20-21, dst_port in bytes 22-23.
- beat3: seq in bytes 24-27.
- beat4: flags in byte 33.
REQ-012 State machine SHALL have states HDR, DRAIN and RESULT:
- HDR -> DRAIN when beat4 is accepted without tlast.
- HDR/DRAIN -> RESULT on the tlast handshake.
- RESULT -> HDR on the out_valid&&out_ready handshake.
REQ-013 s_axis_tready SHALL be 1 in HDR and DRAIN and 0 in RESULT, so frames are never dropped; each frame costs one bubble cycle after the result is accepted.
REQ-014 out_valid SHALL assert the cycle after the tlast handshake and hold, with all result fields stable, until out_ready is sampled high.
REQ-015 The header checksum SHALL be a 17-bit end-around-carry one's-complement accumulation of the ten 16-bit words in bytes 0-19; csum_ok=1 iff the folded sum equals 16'hFFFF.
REQ-016 err_short SHALL be 1 if tlast arrives before beat4, or if beat4 carries tlast with tkeep[7:6]!=2'b11; fields from beats not received SHALL read zero, and csum_ok=0 if beat2 was not received.
REQ-017 err_ver SHALL be 1 iff ip_ver!=4, and err_ihl SHALL be 1 iff ip_ihl!=5; when err_ihl=1, is_tcp=0 and the TCP fields are zero.
REQ-018 is_tcp SHALL be 1 iff ip_proto==6, ihl==5, and err_short=0.
REQ-019 A single-beat frame (tlast on beat0) SHALL produce a result with err_short=1.
REQ-020 Frames longer than five beats SHALL be consumed through tlast in DRAIN; payload is discarded.
REQ-021 The tkeep value of non-last beats SHALL be ignored.

Reset
REQ-022 On rst, the state SHALL go to HDR, beat_cnt and the accumulator SHALL clear, out_valid=0, and all result and status outputs SHALL be 0.
REQ-023 On rst, s_axis_tready SHALL be 0 during the reset cycle and 1 on the following cycle.
REQ-024 Reset mid-frame SHALL discard the partial frame; the next accepted beat is treated as beat0.
REQ-025 Reset while in RESULT SHALL drop the pending record.

Structure
REQ-026 Package ipv4_rx_pkg SHALL hold:
- the result struct typedef;
- constants IPV4_VERSION=4, IPV4_IHL_MIN=5, IP_PROTO_TCP=6, HDR_BEATS=5, CSUM_GOOD=16'hFFFF.
REQ-027 The checksum SHALL live in sub-module ipv4_csum_acc: it sums up to four 16-bit words per beat with a clear input and outputs the folded sum.

Verification
REQ-028 SYN frame test: send 4500002812344000 4006A548C0A80101 C0A8010204D20050 0000000100000000, then 5002721000000000 with tkeep=FC and tlast=1 -> one record with:
- ver=4, ihl=5, total_len=0028, ttl=40, proto=06;
- src=C0A80101, dst=C0A80102, ports 04D2/0050, seq=00000001, flags=02;
- csum_ok=1, is_tcp=1, all err=0.
REQ-029 Checksum test: same frame with checksum field 0000 -> csum_ok=0 and all other fields unchanged.
REQ-030 Short frame test: send 3 beats with tlast on beat2 -> err_short=1, is_tcp=0, tcp_seq=0, and csum_ok valid.
REQ-031 Backpressure test: hold out_ready=0 for 10 cycles after a frame -> s_axis_tready=0 and fields stable throughout; the next frame is accepted after the handshake and decoded correctly.
REQ-032 Option/version test: send a 9-beat frame with byte0=46 (ihl=6) and proto=11 -> err_ihl=1, is_tcp=0, and exactly one record after beat8 tlast.
REQ-033 Mid-frame reset test: assert rst after beat1, then send the full SYN frame -> a single correct record.
